// File: rtl/pixie_dma_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pixie_dma_scheduler
// Description : CDP1861-style display DMA sequencer for the Studio II Pixie
//               path. Counts line/frame timing in machine cycles, raises
//               DMAO request windows, captures DMA bytes into the 256-byte
//               frame-buffer write port and generates INT / EFx.
// Revision    : 1.0 - initial release
// ============================================================================
module pixie_dma_scheduler #(
  parameter int          LINE_CYCLES     = 14,
  parameter int          LINES_PER_FRAME = 262,
  parameter int          DISPLAY_START   = 64,
  parameter int          DISPLAY_END     = 192,
  parameter int          INT_LINE        = 62,
  parameter int          DMA_START_CYCLE = 2,
  parameter int          BYTES_PER_LINE  = 8,
  parameter int          LINE_REPEAT     = 4,
  parameter logic [15:0] START_ADDR      = 16'h0900
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [1:0]  SC,
  input  logic        disp_on,
  input  logic        disp_off,
  input  logic [7:0]  data_in,
  output logic        DMAO,
  output logic        INT,
  output logic        EFx,
  output logic [15:0] dma_addr,
  output logic        fb_we,
  output logic [7:0]  fb_waddr,
  output logic [7:0]  fb_wdata,
  output logic        frame_start,
  output logic        display_enabled,
  output logic        dma_underrun
);

  localparam int CW = $clog2(LINE_CYCLES);
  localparam int LW = $clog2(LINES_PER_FRAME);
  localparam int BW = $clog2(BYTES_PER_LINE + 1);

  localparam logic [CW-1:0] CYC_LAST   = CW'(LINE_CYCLES - 1);
  localparam logic [CW-1:0] CYC_DMA    = CW'(DMA_START_CYCLE);
  localparam logic [LW-1:0] LINE_LAST  = LW'(LINES_PER_FRAME - 1);
  localparam logic [LW-1:0] DISP_FIRST = LW'(DISPLAY_START);
  localparam logic [LW-1:0] DISP_STOP  = LW'(DISPLAY_END);
  localparam logic [LW-1:0] REPEAT     = LW'(LINE_REPEAT);
  localparam logic [LW-1:0] INT_FIRST  = LW'(INT_LINE);
  localparam logic [LW-1:0] INT_SECOND = LW'(INT_LINE + 1);
  localparam logic [LW-1:0] EF_TOP     = LW'(DISPLAY_START - 4);
  localparam logic [LW-1:0] EF_BOTTOM  = LW'(DISPLAY_END - 4);
  localparam logic [7:0]    ROW_BYTES  = 8'(BYTES_PER_LINE);
  localparam logic [BW-1:0] BYTE_LAST  = BW'(BYTES_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    REQUEST   = 2'd2,
    LINE_DONE = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cyc, cyc_n;
  logic [LW-1:0] line, line_n;
  logic [BW-1:0] byte_cnt, cnt_n;
  logic [15:0]   addr_n;
  logic [7:0]    waddr_n, wdata_n;
  logic          en_n, en_fall, cyc_wrap, accept;
  logic          dmao_n, we_n, ur_n, int_n, efx_n, fs_n;

  // Row geometry of the current line; the line is stable for a whole request.
  logic [LW-1:0] rel, row;
  logic          fetch_line;
  logic [7:0]    row_base;

  assign rel        = line - DISP_FIRST;
  assign row        = rel / REPEAT;
  assign fetch_line = (line >= DISP_FIRST) && (line < DISP_STOP) && ((rel % REPEAT) == '0);
  assign row_base   = 8'(row) * ROW_BYTES;

  // Next-state, counter and output computation for one machine-cycle tick.
  always_comb begin
    state_n  = state;
    dmao_n   = DMAO;
    cnt_n    = byte_cnt;
    addr_n   = dma_addr;
    waddr_n  = fb_waddr;
    wdata_n  = fb_wdata;
    we_n     = 1'b0;
    ur_n     = 1'b0;
    accept   = (SC == 2'b10);

    // disp_on has priority over disp_off on the same tick.
    en_n     = disp_on ? 1'b1 : (disp_off ? 1'b0 : display_enabled);
    en_fall  = display_enabled && !en_n;

    cyc_wrap = (cyc == CYC_LAST);
    cyc_n    = cyc_wrap ? '0 : cyc + CW'(1);
    line_n   = cyc_wrap ? ((line == LINE_LAST) ? '0 : line + LW'(1)) : line;

    if (en_fall) begin
      // Abandon any partial row silently.
      state_n = IDLE;
      dmao_n  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (display_enabled) state_n = WAIT_LINE;
        end
        WAIT_LINE: begin
          if (!display_enabled) begin
            state_n = IDLE;
          end else if (cyc == CYC_DMA && fetch_line) begin
            state_n = REQUEST;
            dmao_n  = 1'b0;
            cnt_n   = '0;
            addr_n  = START_ADDR + {8'h00, row_base};
          end
        end
        REQUEST: begin
          if (accept) begin
            wdata_n = data_in;
            waddr_n = row_base + 8'(byte_cnt);
            we_n    = 1'b1;
            cnt_n   = byte_cnt + BW'(1);
            addr_n  = dma_addr + 16'd1;
          end
          if (accept && byte_cnt == BYTE_LAST) begin
            dmao_n  = 1'b1;
            state_n = LINE_DONE;
          end else if (cyc_wrap) begin
            // Line ended before the row completed; a byte taken now still counts.
            ur_n    = 1'b1;
            dmao_n  = 1'b1;
            state_n = LINE_DONE;
          end
        end
        LINE_DONE: begin
          if (!display_enabled) state_n = IDLE;
          else if (cyc == '0)   state_n = WAIT_LINE;
        end
        default: state_n = IDLE;
      endcase
    end

    int_n = en_n && (line_n == INT_FIRST || line_n == INT_SECOND);
    efx_n = !((line_n >= EF_TOP && line_n < DISP_FIRST) ||
              (line_n >= EF_BOTTOM && line_n < DISP_STOP));
    fs_n  = (line_n == '0) && (cyc_n == '0);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset)           state <= IDLE;
    else if (clk_enable) state <= state_n;
  end

  // Counters and registered outputs; strobes last exactly one clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc             <= '0;
      line            <= '0;
      byte_cnt        <= '0;
      display_enabled <= 1'b0;
      DMAO            <= 1'b1;
      INT             <= 1'b0;
      EFx             <= 1'b1;
      dma_addr        <= START_ADDR;
      fb_we           <= 1'b0;
      fb_waddr        <= 8'h00;
      fb_wdata        <= 8'h00;
      frame_start     <= 1'b0;
      dma_underrun    <= 1'b0;
    end else begin
      fb_we        <= 1'b0;
      frame_start  <= 1'b0;
      dma_underrun <= 1'b0;
      if (clk_enable) begin
        cyc             <= cyc_n;
        line            <= line_n;
        byte_cnt        <= cnt_n;
        display_enabled <= en_n;
        DMAO            <= dmao_n;
        INT             <= int_n;
        EFx             <= efx_n;
        dma_addr        <= addr_n;
        fb_we           <= we_n;
        fb_waddr        <= waddr_n;
        fb_wdata        <= wdata_n;
        frame_start     <= fs_n;
        dma_underrun    <= ur_n;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/pixie_dma_scheduler.md
Name: pixie_dma_scheduler

Overview:
- Sequences CDP1861-style display DMA for the Studio II Pixie path: frame/line timing, DMAO request windows, CPU DMA acknowledgement via SC, INT/EFx generation.
- Captures DMA bytes into the 256-byte frame-buffer write port consumed by the video back end.
- Sits between the CDP1802 bus (clk_enable domain) and the pixie video generator.
- All timing is counted in clk_enable ticks, where one tick is one machine cycle.

Parameters:
- LINE_CYCLES, 14, machine cycles per scan line.
- LINES_PER_FRAME, 262, lines per frame (NTSC).
- DISPLAY_START, 64, first active line.
- DISPLAY_END, 192, first line after the active area.
- INT_LINE, 62, first line of the 2-line INT pulse.
- DMA_START_CYCLE, 2, line cycle at which DMAO asserts.
- BYTES_PER_LINE, 8, DMA bytes per fetched row.
- LINE_REPEAT, 4, scan lines per fetched row.
- START_ADDR, 16'h0900, display memory base.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- clk_enable  in  1  machine-cycle strobe; all state advances only when high
- SC  in  2  CPU state code; 2'b10 = DMA cycle
- disp_on  in  1  display enable strobe
- disp_off  in  1  display disable strobe
- data_in  in  8  CPU data bus during DMA cycle
- DMAO  out  1  DMA-out request, active low
- INT  out  1  interrupt request, active high
- EFx  out  1  EF1 flag, active low
- dma_addr  out  16  address of the current DMA byte
- fb_we  out  1  frame-buffer write strobe, 1 clk wide
- fb_waddr  out  8  frame-buffer byte index
- fb_wdata  out  8  frame-buffer byte
- frame_start  out  1  1-clk pulse at line 0, cycle 0
- display_enabled  out  1  current enable state
- dma_underrun  out  1  1-clk pulse when a row fetch did not complete

Behaviour:
- Reset values: DMAO=1, INT=0, EFx=1, fb_we=0, frame_start=0, dma_underrun=0, display_enabled=0. Counters, dma_addr=START_ADDR, fb_waddr=0, fb_wdata=0, state=IDLE.
- Counters (per clk_enable tick):
  - cyc 0..LINE_CYCLES-1; line increments when cyc wraps; line wraps LINES_PER_FRAME-1 -> 0.
  - Counters run regardless of display enable.
- Enable control: disp_on sets display_enabled; disp_off clears it; disp_on wins when both are high on the same tick.
- Fetch line: active line where (line-DISPLAY_START) mod LINE_REPEAT == 0.
  - row = (line-DISPLAY_START)/LINE_REPEAT, range 0..31.
  - Row base = row*BYTES_PER_LINE, 8-bit, wraps at 256.
- FSM states: IDLE, WAIT_LINE, REQUEST, LINE_DONE.
  - IDLE: DMAO=1. Goes to WAIT_LINE when display_enabled.
  - WAIT_LINE: goes to REQUEST at cyc==DMA_START_CYCLE on a fetch line. DMAO goes low on the same tick. byte_cnt=0. dma_addr=START_ADDR+row base.
  - REQUEST: each tick with SC==2'b10 is an accepted byte:
    - fb_wdata<=data_in, fb_waddr<=row base+byte_cnt, fb_we pulses 1 clk.
    - byte_cnt++, dma_addr++.
    - On the tick accepting byte BYTES_PER_LINE-1: DMAO<=1, go to LINE_DONE.
    - Any other SC value is a wait; byte_cnt holds.
  - REQUEST underrun: if cyc==LINE_CYCLES-1 is reached with byte_cnt<BYTES_PER_LINE:
    - A byte accepted on that same tick is still written.
    - dma_underrun pulses, DMAO<=1, go to LINE_DONE.
    - Remaining bytes of the row keep their previous frame-buffer contents.
  - LINE_DONE: goes to WAIT_LINE at the next line start. Goes to IDLE if display_enabled=0.
  - Any state: display_enabled falling forces IDLE on the same tick. DMAO<=1 that tick; a partial row is abandoned with no underrun pulse.
- INT: 1 during lines INT_LINE and INT_LINE+1 when display_enabled, else 0.
- EFx: 0 during lines DISPLAY_START-4..DISPLAY_START-1 and DISPLAY_END-4..DISPLAY_END-1, regardless of enable; else 1.
- frame_start: pulses on the tick the counters become line 0, cyc 0.
- Latency: outputs are registered, updated on the clk edge of the qualifying clk_enable tick. Nothing changes when clk_enable=0 (fb_we, frame_start and dma_underrun drop after 1 clk).
- disp_on mid-frame: DMA begins at the next fetch line at DMA_START_CYCLE, never mid-line.
- Reset mid-operation: returns everything to reset values on the next clk and aborts any pending DMA.

Test Plan:
- Reset, then disp_on, SC=2'b10 throughout, data_in=incrementing -> per frame exactly 32 fetch lines, each with 8 fb_we pulses. fb_waddr covers 0..255 once. dma_addr covers 0x0900..0x09FF. DMAO low exactly 8 ticks per fetch line from cyc 2.
- Display enabled -> INT high only on lines 62-63. EFx low on lines 60-63 and 188-191. frame_start once every 262*14 ticks.
- SC=2'b10 only on alternate ticks -> row completes by cyc 17 > 13, so only bytes 0..5 are written. dma_underrun pulses once per fetch line at cyc 13. DMAO releases at cyc 13.
- disp_off after 3 bytes of row 5 -> DMAO=1 on the same tick. No further fb_we. No underrun. INT stays 0 in the next frame.
- disp_on and disp_off on the same tick -> display_enabled=1.
- Reset asserted mid-REQUEST -> all outputs return to reset values next clk. After release, no DMA occurs until disp_on.
